// File: rtl/beam_thresh_scheduler.sv
// Threshold-bus sequencer: keeps a shadow copy and a dirty flag per beam, streams the dirty
// thresholds onto the shared bus on commit, then issues one global update pulse.
module beam_thresh_scheduler #(
    parameter int                     NBEAMS         = 2,
    parameter int                     THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = {THRESH_BITS{1'b1}},
    parameter int                     BIDX_BITS      = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [BIDX_BITS-1:0]   wr_beam_i,
    input  logic [THRESH_BITS-1:0] wr_thresh_i,
    input  logic                   commit_i,
    output logic [THRESH_BITS-1:0] thresh_o,
    output logic [NBEAMS-1:0]      thresh_ce_o,
    output logic                   update_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    // Write port: a beat transfers on a rising edge where wr_valid_i and wr_ready_o are both high;
    // the requester holds beam and data stable until then, and ready never depends on valid.

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_UPDATE
    } state_e;

    localparam logic [BIDX_BITS-1:0] LAST_IDX   = BIDX_BITS'(NBEAMS - 1);
    localparam logic [BIDX_BITS:0]   NBEAMS_EXT = (BIDX_BITS + 1)'(NBEAMS);

    state_e                 state_q, state_d;
    logic [BIDX_BITS-1:0]   idx_q, idx_d;
    logic                   pend_q, pend_d;

    logic [THRESH_BITS-1:0] shadow_q [NBEAMS];
    logic [NBEAMS-1:0]      dirty_q;

    logic                   wr_accept;
    logic                   wr_in_range;
    logic [NBEAMS-1:0]      wr_hit;
    logic [NBEAMS-1:0]      scan_hit;
    logic [THRESH_BITS-1:0] scan_val;
    logic                   scan_dirty;

    always_comb begin
        wr_accept   = wr_valid_i && wr_ready_o && (state_q == ST_IDLE);
        wr_in_range = ({1'b0, wr_beam_i} < NBEAMS_EXT);
        wr_hit      = '0;
        scan_hit    = '0;
        scan_val    = '0;
        for (int i = 0; i < NBEAMS; i++) begin
            wr_hit[i]   = wr_accept && (wr_beam_i == BIDX_BITS'(i));
            scan_hit[i] = (idx_q == BIDX_BITS'(i));
            if (scan_hit[i]) begin
                scan_val = shadow_q[i];
            end
        end
        scan_dirty = |(scan_hit & dirty_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // A commit that arrives during UPDATE with a rerun already pending is absorbed by that rerun.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (commit_i || pend_q) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (commit_i) begin
                    pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_UPDATE;
                end else begin
                    idx_d = idx_q + BIDX_BITS'(1);
                end
            end
            ST_UPDATE: begin
                if (pend_q) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = commit_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NBEAMS; i++) begin
                shadow_q[i] <= THRESH_DEFAULT;
            end
            dirty_q     <= '1;
            thresh_o    <= '0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            wr_ready_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            for (int i = 0; i < NBEAMS; i++) begin
                if (wr_hit[i]) begin
                    shadow_q[i] <= wr_thresh_i;
                    dirty_q[i]  <= 1'b1;
                end else if ((state_q == ST_SCAN) && scan_hit[i]) begin
                    dirty_q[i] <= 1'b0;
                end
            end
            if (wr_accept && !wr_in_range) begin
                err_o <= 1'b1;
            end
            thresh_ce_o <= '0;
            if ((state_q == ST_SCAN) && scan_dirty) begin
                thresh_o    <= scan_val;
                thresh_ce_o <= scan_hit;
            end
            update_o   <= (state_q == ST_UPDATE);
            done_o     <= (state_q == ST_UPDATE);
            busy_o     <= (state_q != ST_IDLE);
            // Ready follows the next state so no write slips in on the edge that leaves IDLE.
            wr_ready_o <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_beam_thresh_scheduler.sv
// Randomised scoreboard bench for beam_thresh_scheduler: a commit-level model predicts every
// strobe and update pulse with its cycle number; a monitor compares each bus event in order.
module tb_beam_thresh_scheduler;
  localparam int NB = 2;
  localparam int TB = 18;
  localparam int BB = 2;
  localparam int W  = 32 + 1 + NB + TB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [BB-1:0] wr_beam = '0;
  logic [TB-1:0] wr_thresh = '0;
  logic          commit = 1'b0;
  logic [TB-1:0] thresh;
  logic [NB-1:0] thresh_ce;
  logic          update;
  logic          busy;
  logic          done;
  logic          err;

  beam_thresh_scheduler #(
    .NBEAMS(NB),
    .THRESH_BITS(TB),
    .THRESH_DEFAULT(18'h3FFFF),
    .BIDX_BITS(BB)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready),
    .wr_beam_i(wr_beam),
    .wr_thresh_i(wr_thresh),
    .commit_i(commit),
    .thresh_o(thresh),
    .thresh_ce_o(thresh_ce),
    .update_o(update),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: shadow/dirty arrays and the edge numbers of each run
  logic [TB-1:0] m_shadow [NB];
  bit            m_dirty  [NB];
  logic [TB-1:0] m_last;
  bit            m_err;
  int            run_end;     // edge that samples the UPDATE cycle of the latest run
  int            pend_start;  // first edge of the queued rerun

  function void model_reset();
    for (int b = 0; b < NB; b++) begin
      m_shadow[b] = 18'h3FFFF;
      m_dirty[b]  = 1'b1;
    end
    m_last     = '0;
    m_err      = 1'b0;
    run_end    = -100;
    pend_start = -100;
    exp_q.delete();
  endfunction

  function void model_write(input int beam, input logic [TB-1:0] val);
    if (beam < NB) begin
      m_shadow[beam] = val;
      m_dirty[beam]  = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // j = edge on which commit is sampled
  function void model_commit(input int j);
    int k;
    logic [NB-1:0] ce;
    if (j > run_end) begin
      k = j;
    end else if (pend_start >= j) begin
      return;
    end else begin
      k = (j == run_end) ? run_end + 1 : run_end;
      pend_start = k;
    end
    for (int b = 0; b < NB; b++) begin
      if (m_dirty[b]) begin
        ce = '0;
        ce[b] = 1'b1;
        exp_q.push_back({32'(k + 1 + b), 1'b0, ce, m_shadow[b]});
        m_last = m_shadow[b];
        m_dirty[b] = 1'b0;
      end
    end
    exp_q.push_back({32'(k + 1 + NB), 1'b1, {NB{1'b0}}, m_last});
    run_end = k + NB + 1;
  endfunction

  task check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && (update || (thresh_ce != '0))) begin
        act = {32'(edge_cnt), update, thresh_ce, thresh};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got cyc=%0d upd=%0b ce=%b thresh=%h, required no event",
                   act[W-1 -: 32], act[NB+TB], act[TB +: NB], act[TB-1:0]);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL sb_event: got cyc=%0d upd=%0b ce=%b thresh=%h, required cyc=%0d upd=%0b ce=%b thresh=%h",
                     act[W-1 -: 32], act[NB+TB], act[TB +: NB], act[TB-1:0],
                     exp[W-1 -: 32], exp[NB+TB], exp[TB +: NB], exp[TB-1:0]);
          end
        end
        if (done !== update) begin
          errors++;
          $display("FAIL done_vs_update: got done=%0b, required %0b", done, update);
        end
      end
    end
  endtask

  // driver tasks: all start and end just after a falling edge
  task do_commit();
    commit = 1'b1;
    model_commit(edge_cnt + 1);
    @(negedge clk);
    commit = 1'b0;
  endtask

  task do_write(input int beam, input logic [TB-1:0] val, input bit with_commit);
    int n;
    n = 0;
    wr_valid  = 1'b1;
    wr_beam   = beam[BB-1:0];
    wr_thresh = val;
    while (!wr_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!wr_ready) begin
      errors++;
      $display("FAIL wr_timeout: ready=0 after %0d cycles, required 1", n);
    end else begin
      if (edge_cnt + 1 <= run_end) begin
        errors++;
        $display("FAIL wr_ready_busy: accepted on edge %0d, required after %0d", edge_cnt + 1, run_end);
      end
      if (with_commit) commit = 1'b1;
      model_write(beam, val);
      if (with_commit) model_commit(edge_cnt + 1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task wait_idle();
    int n;
    n = 0;
    while (n < 100 && (edge_cnt <= run_end || busy)) begin
      if (edge_cnt == run_end) check("busy_at_update", busy, 1);
      @(negedge clk);
      n++;
    end
    check("busy_fall_cycle", edge_cnt, run_end + 1);
    check("queue_drained", exp_q.size(), 0);
    check("ready_in_idle", wr_ready, 1);
  endtask

  task check_reset_outputs(input string tag);
    check({tag, "_thresh"}, thresh, 0);
    check({tag, "_ce"}, thresh_ce, 0);
    check({tag, "_update"}, update, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, wr_ready, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int nw;
    int n;
    bit committed;
    bit wc;
    fork
      monitor();
    join_none

    // power-on reset and automatic default reload
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    model_commit(edge_cnt + 1);
    @(negedge clk);
    check("rel_busy", busy, 0);
    check("rel_ready", wr_ready, 0);
    wait_idle();

    // write and commit in one cycle, then a commit with nothing dirty
    do_write(1, 18'd1200, 1'b1);
    wait_idle();
    do_commit();
    wait_idle();

    // commits during SCAN collapse into a single rerun
    do_write(0, TB'($urandom()), 1'b0);
    do_write(1, TB'($urandom()), 1'b0);
    do_commit();
    do_commit();
    do_commit();
    wait_idle();

    // write held during a scan is back-pressured, then emitted by a later commit
    do_write(0, TB'($urandom()), 1'b0);
    do_commit();
    check("ready_during_scan", wr_ready, 0);
    do_write(1, TB'($urandom()), 1'b0);
    do_commit();
    wait_idle();

    // out-of-range beam index
    check("err_before", err, 0);
    do_write(3, TB'($urandom()), 1'b0);
    check("err_set", err, 1);
    do_commit();
    wait_idle();
    check("err_sticky", err, 1);

    // randomised writes and commits
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 3);
      committed = 1'b0;
      for (int i = 0; i < nw; i++) begin
        wc = (i == nw - 1) && ($urandom_range(0, 1) == 1);
        do_write($urandom_range(0, 3), TB'($urandom()), wc);
        if (wc) committed = 1'b1;
      end
      if (!committed) do_commit();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        do_commit();
      end
      wait_idle();
      check("err_model", err, m_err);
    end

    // reset asserted during the beam1 slot
    do_write(1, TB'($urandom()), 1'b1);
    n = 0;
    while (!thresh_ce[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beam1_slot_seen", thresh_ce, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_commit(edge_cnt + 1);
    wait_idle();

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/beam_thresh_scheduler.md
Name: beam_thresh_scheduler

Overview:
Configuration sequencer for the beamformer threshold bus. The beamformer receives thresholds on a shared 18-bit thresh bus with a per-beam one-hot thresh_ce and a global update strobe. This block holds a per-beam shadow copy of each threshold plus a dirty flag. On a commit it walks all beams, writes only the dirty thresholds onto the shared bus, and then issues a single update pulse so that all new thresholds take effect together.

Parameters:
NBEAMS, 2, number of beams driven; legal range 1..64.
THRESH_BITS, 18, threshold width; must equal the beamformer thresh_i width.
THRESH_DEFAULT, 18'h3FFFF, shadow value loaded at reset (maximum value, so nothing triggers).
BIDX_BITS, $clog2(NBEAMS) (minimum 1), width of the beam index.

Ports:
clk_i  in  1  beamformer clock.
rst_ni  in  1  asynchronous active-low reset.
wr_valid_i  in  1  shadow-write request.
wr_ready_o  out  1  shadow write accepted when high together with wr_valid_i.
wr_beam_i  in  BIDX_BITS  target beam index.
wr_thresh_i  in  THRESH_BITS  new threshold value.
commit_i  in  1  one-cycle pulse requesting that staged thresholds be pushed to the beamformer.
thresh_o  out  THRESH_BITS  to beamformer thresh_i.
thresh_ce_o  out  NBEAMS  to beamformer thresh_ce_i; one-hot or zero.
update_o  out  1  to beamformer update_i.
busy_o  out  1  high whenever state is not IDLE.
done_o  out  1  one-cycle pulse, coincident with update_o.
err_o  out  1  sticky flag; set by a write whose beam index is >= NBEAMS.

Behaviour:
- All outputs are registered.
- Reset values:
  - thresh_o=0, thresh_ce_o=0, update_o=0, done_o=0, err_o=0.
  - busy_o=0 and wr_ready_o=0 for the first cycle after reset release.
  - Every shadow register = THRESH_DEFAULT; every dirty bit = 1; pend_commit = 1.
  - Consequence: the defaults are loaded automatically after reset with no software action.
- States: IDLE, SCAN, UPDATE.
- IDLE:
  - wr_ready_o=1.
  - On an accepted write with wr_beam_i<NBEAMS: shadow[b] <= wr_thresh_i and dirty[b] <= 1.
  - On an accepted write with wr_beam_i>=NBEAMS: the write is dropped (ready is still given) and err_o is set.
  - A commit_i pulse, or pend_commit=1, moves the FSM to SCAN on the next edge with idx=0; pend_commit is cleared.
  - A write and a commit in the same IDLE cycle: the write lands first, so it is included in that commit.
- SCAN:
  - wr_ready_o=0. busy_o=1.
  - Exactly one beam index per cycle, idx = 0..NBEAMS-1, ascending.
  - If dirty[idx]: thresh_o=shadow[idx], thresh_ce_o=1<<idx, and dirty[idx] is cleared. Otherwise thresh_ce_o=0 and thresh_o holds its last value.
  - After idx=NBEAMS-1 the FSM goes to UPDATE.
- UPDATE:
  - One cycle: update_o=1, done_o=1, thresh_ce_o=0.
  - The next state is IDLE. If pend_commit=1, the FSM re-enters SCAN directly with idx=0 and busy_o stays high.
- Timing: commit_i sampled at edge k gives:
  - busy_o high from k+1;
  - the beam b strobe in the cycle after edge k+1+b;
  - update_o and done_o in the cycle after edge k+1+NBEAMS;
  - busy_o low after edge k+2+NBEAMS.
  - Total commit latency is NBEAMS+2 cycles.
- commit_i while busy (SCAN or UPDATE): sets pend_commit; it is never lost. Multiple commits while busy collapse into one rerun.
- A commit with no dirty beams still runs the full scan and issues update_o. This re-latch is harmless and keeps the latency deterministic.
- update_o is never asserted in the same cycle as any thresh_ce_o bit.
- Writes are back-pressured during SCAN and UPDATE, so a shadow value cannot change mid-scan.
- Reset asserted mid-operation: all outputs drop immediately (asynchronous). The block returns to the reset state, including the automatic default reload.

Test Plan:
- Reset release, NBEAMS=2: a SCAN runs automatically. thresh_o=18'h3FFFF with thresh_ce_o=2'b01, then 2'b10, then update_o=1 and done_o=1; busy_o falls 4 cycles after leaving IDLE.
- After idle, write beam1=18'd1200 and commit in the same cycle: beam0 slot has ce=0, beam1 slot has thresh_o=1200 and ce=2'b10, update_o follows; the dirty bits read back as clear.
- commit_i pulsed twice during SCAN: exactly one additional SCAN/UPDATE follows with no IDLE gap, then IDLE. Two update pulses total.
- wr_valid_i held during SCAN: wr_ready_o=0 until IDLE; the write is then accepted and a later commit emits the new value.
- Write with wr_beam_i=3 at NBEAMS=2: err_o=1 and stays set; no shadow changes; the next commit strobes no beam but still pulses update_o.
- rst_ni asserted during the beam1 slot: thresh_ce_o and update_o drop immediately. After release, the automatic default reload is observed.
